// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: X - Y - Bin over WIDTH bits, LSB first, one bit per accepted cycle.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bin,
    input  logic             in_valid,
    input  logic             x,
    input  logic             y,
    output logic             busy,
    output logic             diff_valid,
    output logic             diff_bit,
    output logic             done,
    output logic [WIDTH-1:0] diff_word,
    output logic             bout,
    output logic             zero
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             borrow, borrow_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic             busy_nxt, diff_valid_nxt, diff_bit_nxt, done_nxt;
    logic [WIDTH-1:0] diff_word_nxt;
    logic             bout_nxt, zero_nxt;
    logic             d_c, b_c;
    logic [WIDTH-1:0] shifted_c;

    // Full-subtractor cell on the current pair and the running borrow
    assign d_c       = x ^ y ^ borrow;
    assign b_c       = (~x & y) | (~(x ^ y) & borrow);
    assign shifted_c = {d_c, diff_word[WIDTH-1:1]};

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_nxt;
`endif

    always_comb begin
        state_nxt      = state;
        borrow_nxt     = borrow;
        count_nxt      = count;
        diff_valid_nxt = 1'b0;
        diff_bit_nxt   = diff_bit;
        done_nxt       = 1'b0;
        diff_word_nxt  = diff_word;
        bout_nxt       = bout;
        zero_nxt       = zero;
`ifdef SERIAL_SUB_OVF_EN
        ovf_nxt        = ovf;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = RUN;
                    borrow_nxt    = bin;
                    count_nxt     = '0;
                    diff_word_nxt = '0;
                end
            end
            RUN: begin
                if (in_valid) begin
                    diff_bit_nxt   = d_c;
                    diff_valid_nxt = 1'b1;
                    diff_word_nxt  = shifted_c;
                    borrow_nxt     = b_c;
                    count_nxt      = count + CW'(1);
                    // Final pair: publish the end-of-word results alongside done
                    if (count == CW'(WIDTH - 1)) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        bout_nxt  = b_c;
                        zero_nxt  = (shifted_c == '0);
`ifdef SERIAL_SUB_OVF_EN
                        ovf_nxt   = (x != y) && (d_c != x);
`endif
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            borrow     <= 1'b0;
            count      <= '0;
            busy       <= 1'b0;
            diff_valid <= 1'b0;
            diff_bit   <= 1'b0;
            done       <= 1'b0;
            diff_word  <= '0;
            bout       <= 1'b0;
            zero       <= 1'b0;
        end else begin
            state      <= state_nxt;
            borrow     <= borrow_nxt;
            count      <= count_nxt;
            busy       <= busy_nxt;
            diff_valid <= diff_valid_nxt;
            diff_bit   <= diff_bit_nxt;
            done       <= done_nxt;
            diff_word  <= diff_word_nxt;
            bout       <= bout_nxt;
            zero       <= zero_nxt;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else begin
            ovf <= ovf_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=4 with hand-computed expected results.
module tb_serial_subtractor;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         bin = 1'b0;
    logic         in_valid = 1'b0;
    logic         x = 1'b0;
    logic         y = 1'b0;
    logic         busy, diff_valid, diff_bit, done, bout, zero;
    logic [W-1:0] diff_word;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bin        (bin),
        .in_valid   (in_valid),
        .x          (x),
        .y          (y),
        .busy       (busy),
        .diff_valid (diff_valid),
        .diff_bit   (diff_bit),
        .done       (done),
        .diff_word  (diff_word),
        .bout       (bout),
        .zero       (zero)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a word in IDLE; returns with the DUT in RUN at a falling edge
    task automatic begin_word(input logic b);
        start = 1'b1;
        bin   = b;
        @(negedge clk);
        start = 1'b0;
        bin   = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Feed one bit pair and check the registered bit one cycle later
    task automatic feed_bit(input string tag, input logic xb, input logic yb,
                            input logic exp_d, input logic exp_done);
        x        = xb;
        y        = yb;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_dvalid"}, 32'(diff_valid), 32'd1);
        check({tag, "_dbit"},   32'(diff_bit),   32'(exp_d));
        check({tag, "_done"},   32'(done),       32'(exp_done));
    endtask

    // Whole word with continuous in_valid; exp_word bits double as the diff_bit stream
    task automatic run_word(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                            input logic b, input logic [W-1:0] exp_word,
                            input logic exp_bout, input logic exp_zero);
        begin_word(b);
        for (int i = 0; i < int'(W); i++) begin
            feed_bit(tag, xv[i], yv[i], exp_word[i], i == int'(W) - 1);
        end
        check({tag, "_busy_at_done"}, 32'(busy),      32'd0);
        check({tag, "_word"},         32'(diff_word), 32'(exp_word));
        check({tag, "_bout"},         32'(bout),      32'(exp_bout));
        check({tag, "_zero"},         32'(zero),      32'(exp_zero));
        @(negedge clk);
        check({tag, "_done_pulse"},   32'(done),      32'd0);
        check({tag, "_word_hold"},    32'(diff_word), 32'(exp_word));
        check({tag, "_bout_hold"},    32'(bout),      32'(exp_bout));
    endtask

    initial begin
        logic [W-1:0] xs;
        logic [W-1:0] ys;

        // Reset state
        @(negedge clk);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_dval",  32'(diff_valid), 32'd0);
        check("rst_done",  32'(done),       32'd0);
        check("rst_word",  32'(diff_word),  32'd0);
        check("rst_bout",  32'(bout),       32'd0);
        check("rst_zero",  32'(zero),       32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // in_valid in IDLE is ignored
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("idle_ignore_dval", 32'(diff_valid), 32'd0);
        check("idle_ignore_busy", 32'(busy),       32'd0);

        // 5 - 3 = 2, stream 0,1,0,0
        run_word("w5m3", 4'd5, 4'd3, 1'b0, 4'h2, 1'b0, 1'b0);
        // 3 - 5 = -2 -> 0xE with borrow
        run_word("w3m5", 4'd3, 4'd5, 1'b0, 4'hE, 1'b1, 1'b0);
        // 9 - 9 = 0
        run_word("w9m9", 4'd9, 4'd9, 1'b0, 4'h0, 1'b0, 1'b1);
        // 7 - 2 - 1 = 4
        run_word("w7m2b", 4'd7, 4'd2, 1'b1, 4'h4, 1'b0, 1'b0);
        // 0 - 0 - 1 = 0xF with borrow
        run_word("w0m0b", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);

        // Stall 3 cycles after bit 1 with start pulsed mid-word: same 5-3 result
        xs = 4'd5;
        ys = 4'd3;
        begin_word(1'b0);
        feed_bit("stall_b0", xs[0], ys[0], 1'b0, 1'b0);
        feed_bit("stall_b1", xs[1], ys[1], 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            @(negedge clk);
            check("stall_dval", 32'(diff_valid), 32'd0);
            check("stall_done", 32'(done),       32'd0);
            check("stall_busy", 32'(busy),       32'd1);
        end
        start = 1'b0;
        feed_bit("stall_b2", xs[2], ys[2], 1'b0, 1'b0);
        feed_bit("stall_b3", xs[3], ys[3], 1'b0, 1'b1);
        check("stall_word", 32'(diff_word), 32'h2);
        check("stall_bout", 32'(bout),      32'd0);
        @(negedge clk);
        check("stall_no_restart", 32'(busy), 32'd0);

        // Reset after two accepted bits, then a fresh 6 - 1
        begin_word(1'b0);
        feed_bit("rstmid_b0", 1'b0, 1'b1, 1'b1, 1'b0);
        feed_bit("rstmid_b1", 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", 32'(busy),       32'd0);
        check("rstmid_dval", 32'(diff_valid), 32'd0);
        check("rstmid_dbit", 32'(diff_bit),   32'd0);
        check("rstmid_word", 32'(diff_word),  32'd0);
        check("rstmid_bout", 32'(bout),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_idle", 32'(busy), 32'd0);
        run_word("w6m1", 4'd6, 4'd1, 1'b0, 4'h5, 1'b0, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
        run_word("w8m1", 4'd8, 4'd1, 1'b0, 4'h7, 1'b0, 1'b0);
        check("ovf_8m1", 32'(ovf), 32'd1);
        run_word("w2m1", 4'd2, 4'd1, 1'b0, 4'h1, 1'b0, 1'b0);
        check("ovf_2m1", 32'(ovf), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
